// File: rtl/lu_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes on both sides,
// an accumulate path that feeds back the previous result, and a consumed-result counter.
module lu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNTW-1:0]  count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_acc_en;
  logic [WIDTH-1:0] acc_q;

  logic             advance;
  logic             accept;
  logic             move;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;
  assign move     = advance && s1_valid;

  // acc_q always holds the result of the op just ahead, since results enter S2 in order
  assign op_a = s1_acc_en ? acc_q : s1_a;

  always_comb begin
    result = '0;
    case (s1_op)
      3'd0:    result = op_a & s1_b;
      3'd1:    result = op_a | s1_b;
      3'd2:    result = op_a ^ s1_b;
      3'd3:    result = ~(op_a | s1_b);
      3'd4:    result = ~(op_a & s1_b);
      3'd5:    result = ~(op_a ^ s1_b);
      3'd6:    result = ~op_a;
      default: result = s1_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_acc_en <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= op;
      s1_acc_en <= acc_en;
    end else if (move) begin
      s1_valid  <= 1'b0;
    end
  end

  // y/zero/parity keep their last value when S2 drains with nothing behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      acc_q     <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y      <= result;
        zero   <= (result == '0);
        parity <= ^result;
        acc_q  <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (out_valid && out_ready) begin
      count <= count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_lu_pipe.sv
// Directed bench for lu_pipe: literal expectations per scenario plus a queue-based
// reference model checked on every cycle by a negedge monitor.
module tb_lu_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  lu_pipe #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lu_model(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
    case (f)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x | z);
      3'd4: return ~(x & z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return z;
    endcase
  endfunction

  // Reference model: results in acceptance order; accumulate uses previous accepted result.
  logic [7:0] exp_q[$];
  logic [7:0] m_acc;
  logic [3:0] m_count;
  logic       stall_prev;
  logic [7:0] prev_y;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 8'h00;
      m_count = 4'd0;
      stall_prev = 1'b0;
    end else begin
      chk("count_model", count, m_count);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_y", y, prev_y);
      end
      if (out_valid) begin
        chk("zero_of_y", zero, (y == 8'h00));
        chk("parity_of_y", parity, ^y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none", y);
        end else begin
          chk("y_model", y, exp_q.pop_front());
        end
        m_count = m_count + 4'd1;
      end
      stall_prev = out_valid && !out_ready;
      prev_y = y;
      if (in_valid && in_ready) begin
        m_acc = lu_model(op, acc_en ? m_acc : a, b);
        exp_q.push_back(m_acc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic [2:0] dop, input logic dacc);
    in_valid = v;
    a = da;
    b = db;
    op = dop;
    acc_en = dacc;
  endtask

  // Asserts reset now, checks reset values, releases just after the next edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 8'h00);
    chk("rst_zero", zero, 1);
    chk("rst_parity", parity, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] t1_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'h0F, 8'h3C};

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    tick();
    reset_pulse();

    // All eight ops, streaming, first accept at the first edge after release
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8) drive(1, 8'hF0, 8'h3C, 3'(cyc), 0);
      else drive(0, 8'h00, 8'h00, 3'd0, 0);
      if (cyc == 1) chk("t1_latency", out_valid, 0);
      if (cyc >= 2) begin
        chk("t1_valid", out_valid, 1);
        chk("t1_y", y, t1_exp[cyc-2]);
        chk("t1_zero", zero, 0);
        chk("t1_parity", parity, 0);
      end
      tick();
    end

    // Backpressure
    reset_pulse();
    out_ready = 1'b0;
    drive(1, 8'hFF, 8'h0F, 3'd0, 0);
    chk("t2_ready0", in_ready, 1);
    tick();
    drive(1, 8'h10, 8'h01, 3'd1, 0);
    chk("t2_ready1", in_ready, 1);
    tick();
    drive(1, 8'hFF, 8'h00, 3'd2, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ready_low", in_ready, 0);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_y", y, 8'h0F);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t2_ready_reopen", in_ready, 1);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    tick();
    tick();
    tick();
    chk("t2_count", count, 4'd3);
    chk("t2_drained", out_valid, 0);
    chk("t2_y_retained", y, 8'hFF);

    // Accumulate chain
    reset_pulse();
    for (int cyc = 0; cyc < 5; cyc++) begin
      case (cyc)
        0: drive(1, 8'h01, 8'h00, 3'd1, 0);
        1: drive(1, 8'hAA, 8'h02, 3'd1, 1);
        2: drive(1, 8'h55, 8'h04, 3'd1, 1);
        default: drive(0, 8'h00, 8'h00, 3'd0, 0);
      endcase
      if (cyc == 2) chk("t3_y0", y, 8'h01);
      if (cyc == 3) chk("t3_y1", y, 8'h03);
      if (cyc == 4) chk("t3_y2", y, 8'h07);
      tick();
    end

    // Zero and parity flags
    reset_pulse();
    for (int cyc = 0; cyc < 4; cyc++) begin
      case (cyc)
        0: drive(1, 8'hA5, 8'hA5, 3'd2, 0);
        1: drive(1, 8'h55, 8'h01, 3'd7, 0);
        default: drive(0, 8'h00, 8'h00, 3'd0, 0);
      endcase
      if (cyc == 2) begin
        chk("t4_y0", y, 8'h00);
        chk("t4_zero0", zero, 1);
        chk("t4_par0", parity, 0);
      end
      if (cyc == 3) begin
        chk("t4_y1", y, 8'h01);
        chk("t4_zero1", zero, 0);
        chk("t4_par1", parity, 1);
      end
      tick();
    end

    // Reset with both stages full and a nonzero count
    out_ready = 1'b0;
    drive(1, 8'h12, 8'h34, 3'd1, 0);
    tick();
    drive(1, 8'h56, 8'h78, 3'd2, 0);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    chk("t5_full_valid", out_valid, 1);
    chk("t5_full_ready", in_ready, 0);
    chk("t5_count_pre", count, 4'd2);
    reset_pulse();
    out_ready = 1'b1;
    tick();
    chk("t5_no_ghost0", out_valid, 0);
    tick();
    chk("t5_no_ghost1", out_valid, 0);
    drive(1, 8'hFF, 8'h00, 3'd1, 1);
    tick();
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    tick();
    chk("t5_acc_cleared_valid", out_valid, 1);
    chk("t5_acc_cleared_y", y, 8'h00);
    tick();

    // Counter wrap: 17 results into a 4-bit counter
    reset_pulse();
    for (int i = 0; i < 17; i++) begin
      drive(1, 8'(i * 7), 8'(i * 13), 3'(i), 0);
      tick();
    end
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    tick();
    tick();
    tick();
    chk("t6_count_wrap", count, 4'd1);
    chk("model_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
